lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Parameters
REQ-001 SHALL provide parameter WIDTH, default 8, meaning state width; legal range 4..32.
REQ-002 SHALL provide parameter FIB_TAPS, default 8'hB2, meaning the Fibonacci feedback mask; bit i set means state bit i is XORed into feedback.
REQ-003 SHALL provide parameter GAL_TAPS, default 8'h1D, meaning the Galois toggle mask.
REQ-004 SHALL provide parameter INIT, default 1, meaning the reset and recovery state; must be nonzero.

Interface
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: advance the LFSR one step this cycle.
REQ-008 SHALL have port load, input, 1 bit: load seed this cycle.
REQ-009 SHALL have port seed, input, WIDTH bits: value to load.
REQ-010 SHALL have port mode, input, 1 bit: 0 selects Fibonacci, 1 selects Galois; sampled on every step.
REQ-011 SHALL have port r_out, output, WIDTH bits: current state, registered.
REQ-012 SHALL have port bit_out, output, 1 bit: equal to r_out[WIDTH-1].
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse when a step returns the state to the anchor.
REQ-014 SHALL have port period, output, WIDTH bits: step count captured at the last wrap.
REQ-015 SHALL have port lockup, output, 1 bit: one-cycle pulse on zero-state recovery.

Function
REQ-016 Fibonacci step SHALL be next = {s[WIDTH-2:0], fb}, where fb = XOR of s[i] over every i with FIB_TAPS[i]=1.
REQ-017 Galois step SHALL be next = {s[WIDTH-2:0],1'b0} XOR (s[WIDTH-1] ? GAL_TAPS : 0).
REQ-018 Priority SHALL be rst > load > en; with no input active, state, anchor and counters hold.
REQ-019 On load, r_out SHALL become seed one cycle later; seed==0 SHALL load 1 instead.
REQ-020 On load, the anchor SHALL be set to the value loaded and the step counter SHALL clear to 0.
REQ-021 Load SHALL not pulse wrap or lockup, and SHALL not change period.
REQ-022 On each step the internal step counter SHALL increment, saturating at all-ones.
REQ-023 If a step's next state equals the anchor: wrap=1 next cycle, period takes counter+1 (saturating), and the counter clears to 0.
REQ-024 If en=1 while the state is 0 (reachable only with degenerate taps): the state SHALL take INIT, the anchor SHALL take INIT, the counter SHALL clear, lockup SHALL be 1 next cycle, and there SHALL be no wrap.
REQ-025 wrap and lockup SHALL be registered, high for exactly one cycle per event, and low otherwise.
REQ-026 A mode change mid-run SHALL take effect on the next step, with no reset of the anchor or counter.
REQ-027 Latency from en/load to r_out SHALL be one clock; there are no combinational input-to-output paths.

Reset
REQ-028 On rst=1 at a clock edge: r_out=INIT, anchor=INIT, counter=0, period=0, wrap=0, lockup=0.
REQ-029 Reset asserted mid-sequence or together with load/en SHALL override both.
REQ-030 The first step after reset SHALL use the mode value present on that step.

Verification (WIDTH=8, defaults)
REQ-031 rst, then mode=0 with en=1 for 7 cycles -> r_out sequence 01,02,05,0A,15,2B,56,AC.
REQ-032 rst, then mode=1 with en=1 -> 01,02,04,08,10,20,40,80,1D,3A,74,E8,CD; after 255 steps wrap pulses once, period=255, and r_out is never 00.
REQ-033 load=1 seed=AB, then mode=0 en=1 -> AB, then 57; load=1 seed=FF then one step -> FE; load seed=00 -> 01.
REQ-034 load and en asserted together with seed=AB -> r_out=AB with no step; rst asserted together with load -> r_out=01, period=00.
REQ-035 Degenerate taps (FIB_TAPS=8'h02): load seed=80, mode=0, step until state is 00, then step again -> r_out=01 and a lockup pulse, with no wrap.
REQ-036 Hold en=0 for 10 cycles mid-run -> r_out, period and counter unchanged; wrap and lockup stay 0.

Source files
------------

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci/Galois LFSR with seed load, period measurement and zero-state recovery
module lfsr_gen #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(8'hB2),
  parameter logic [WIDTH-1:0] GAL_TAPS = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] INIT     = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  output logic [WIDTH-1:0] r_out,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] anchor;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] seed_eff;

  always_comb begin
    fib_next  = {state[WIDTH-2:0], ^(state & FIB_TAPS)};
    gal_next  = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_TAPS : '0);
    step_next = mode ? gal_next : fib_next;
    cnt_inc   = (cnt == '1) ? cnt : cnt + WIDTH'(1);
    // An all-zero seed would lock the register, so it is replaced by 1.
    seed_eff  = (seed == '0) ? WIDTH'(1) : seed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      anchor <= INIT;
      cnt    <= '0;
      period <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (load) begin
        state  <= seed_eff;
        anchor <= seed_eff;
        cnt    <= '0;
      end else if (en) begin
        if (state == '0) begin
          // Degenerate taps can reach zero; restart from INIT without a wrap.
          state  <= INIT;
          anchor <= INIT;
          cnt    <= '0;
          lockup <= 1'b1;
        end else if (step_next == anchor) begin
          state  <= step_next;
          wrap   <= 1'b1;
          period <= cnt_inc;
          cnt    <= '0;
        end else begin
          state  <= step_next;
          cnt    <= cnt_inc;
        end
      end
    end
  end

  assign r_out   = state;
  assign bit_out = state[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed bench for lfsr_gen with default and degenerate taps
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       mode = 1'b0;
  logic [7:0] r_out, period, r_out2, period2;
  logic       bit_out, wrap, lockup, bit_out2, wrap2, lockup2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed), .mode(mode),
    .r_out(r_out), .bit_out(bit_out), .wrap(wrap), .period(period), .lockup(lockup)
  );

  lfsr_gen #(.WIDTH(8), .FIB_TAPS(8'h02)) dut_deg (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed), .mode(mode),
    .r_out(r_out2), .bit_out(bit_out2), .wrap(wrap2), .period(period2), .lockup(lockup2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gal(input logic [7:0] s);
    logic [7:0] sh;
    sh = {s[6:0], 1'b0};
    return s[7] ? (sh ^ 8'h1D) : sh;
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load = 1'b1; en = 1'b1; seed = 8'h5A;
    rst = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    total++; if (r_out !== 8'h01) begin bad++; $display("FAIL reset_r_out got=%h exp=01", r_out); end
    total++; if (bit_out !== 1'b0) begin bad++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
    total++; if (period !== 8'h00) begin bad++; $display("FAIL reset_period got=%h exp=00", period); end
    total++; if (wrap !== 1'b0 || lockup !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", wrap, lockup); end
  endtask

  task automatic test_fibonacci();
    logic [7:0] exp_seq [8];
    exp_seq = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h15, 8'h2B, 8'h56, 8'hAC};
    do_reset();
    mode = 1'b0; en = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      total++; if (r_out !== exp_seq[i]) begin bad++; $display("FAIL fib_step%0d got=%h exp=%h", i, r_out, exp_seq[i]); end
    end
    total++; if (bit_out !== 1'b1) begin bad++; $display("FAIL fib_bit_out got=%b exp=1", bit_out); end
    en = 1'b0;
  endtask

  task automatic test_galois_wrap();
    logic [7:0] exp_seq [13];
    logic [7:0] model;
    int wraps;
    int zeros;
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD};
    do_reset();
    mode = 1'b1; en = 1'b1;
    model = 8'h01; wraps = 0; zeros = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      model = gal(model);
      if (wrap === 1'b1) wraps++;
      if (r_out === 8'h00) zeros++;
      if (i <= 12) begin
        total++; if (r_out !== exp_seq[i]) begin bad++; $display("FAIL gal_step%0d got=%h exp=%h", i, r_out, exp_seq[i]); end
      end else begin
        total++; if (r_out !== model) begin bad++; $display("FAIL gal_model%0d got=%h exp=%h", i, r_out, model); end
      end
    end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL gal_wrap_pulse got=%b exp=1", wrap); end
    total++; if (period !== 8'd255) begin bad++; $display("FAIL gal_period got=%0d exp=255", period); end
    total++; if (wraps != 1) begin bad++; $display("FAIL gal_wrap_count got=%0d exp=1", wraps); end
    total++; if (zeros != 0) begin bad++; $display("FAIL gal_zero_seen got=%0d exp=0", zeros); end
    tick();
    total++; if (wrap !== 1'b0 || r_out !== 8'h02) begin bad++; $display("FAIL gal_after_wrap got=%b/%h exp=0/02", wrap, r_out); end
    en = 1'b0;
  endtask

  task automatic test_load();
    mode = 1'b0; en = 1'b0;
    load = 1'b1; seed = 8'hAB;
    tick();
    load = 1'b0;
    total++; if (r_out !== 8'hAB) begin bad++; $display("FAIL load_ab got=%h exp=ab", r_out); end
    total++; if (period !== 8'd255 || wrap !== 1'b0 || lockup !== 1'b0) begin bad++; $display("FAIL load_side got=%h/%b/%b exp=ff/0/0", period, wrap, lockup); end
    en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (r_out !== 8'h57) begin bad++; $display("FAIL load_ab_step got=%h exp=57", r_out); end
    load = 1'b1; seed = 8'hFF;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (r_out !== 8'hFE) begin bad++; $display("FAIL load_ff_step got=%h exp=fe", r_out); end
    load = 1'b1; seed = 8'h00;
    tick();
    load = 1'b0;
    total++; if (r_out !== 8'h01) begin bad++; $display("FAIL load_zero got=%h exp=01", r_out); end
  endtask

  task automatic test_priority();
    mode = 1'b0;
    load = 1'b1; en = 1'b1; seed = 8'hAB;
    tick();
    load = 1'b0; en = 1'b0;
    total++; if (r_out !== 8'hAB) begin bad++; $display("FAIL prio_load_en got=%h exp=ab", r_out); end
    rst = 1'b1; load = 1'b1; seed = 8'h77;
    tick();
    rst = 1'b0; load = 1'b0;
    total++; if (r_out !== 8'h01 || period !== 8'h00) begin bad++; $display("FAIL prio_rst_load got=%h/%h exp=01/00", r_out, period); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    mode = 1'b1;
    tick();
    total++; if (r_out !== 8'h14) begin bad++; $display("FAIL mode_to_gal got=%h exp=14", r_out); end
    mode = 1'b0;
    tick();
    en = 1'b0;
    total++; if (r_out !== 8'h29) begin bad++; $display("FAIL mode_to_fib got=%h exp=29", r_out); end
  endtask

  task automatic test_hold();
    logic [7:0] model;
    int wraps;
    do_reset();
    mode = 1'b1; en = 1'b1;
    model = 8'h01; wraps = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      model = gal(model);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (r_out !== model || wrap !== 1'b0 || lockup !== 1'b0 || period !== 8'h00) begin
        bad++; $display("FAIL hold_cycle%0d got=%h/%b/%b/%h exp=%h/0/0/00", i, r_out, wrap, lockup, period, model);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 155; i++) begin
      tick();
      if (wrap === 1'b1) wraps++;
    end
    en = 1'b0;
    total++; if (wraps != 1 || wrap !== 1'b1 || period !== 8'd255) begin bad++; $display("FAIL hold_resume got=%0d/%b/%0d exp=1/1/255", wraps, wrap, period); end
  endtask

  task automatic test_lockup();
    do_reset();
    mode = 1'b0;
    load = 1'b1; seed = 8'h80;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    total++; if (r_out2 !== 8'h00 || lockup2 !== 1'b0 || wrap2 !== 1'b0) begin bad++; $display("FAIL deg_to_zero got=%h/%b/%b exp=00/0/0", r_out2, lockup2, wrap2); end
    tick();
    en = 1'b0;
    total++; if (r_out2 !== 8'h01 || lockup2 !== 1'b1 || wrap2 !== 1'b0) begin bad++; $display("FAIL deg_recover got=%h/%b/%b exp=01/1/0", r_out2, lockup2, wrap2); end
    tick();
    total++; if (lockup2 !== 1'b0 || r_out2 !== 8'h01) begin bad++; $display("FAIL deg_pulse_end got=%b/%h exp=0/01", lockup2, r_out2); end
    en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (r_out2 !== 8'h02 || lockup2 !== 1'b0) begin bad++; $display("FAIL deg_after got=%h/%b exp=02/0", r_out2, lockup2); end
  endtask

  initial begin
    test_reset();
    test_fibonacci();
    test_galois_wrap();
    test_load();
    test_priority();
    test_mode_switch();
    test_hold();
    test_lockup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
